// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MIPS multiply/divide unit and HI/LO owner
module muldiv_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  MDop_EX,
    input  logic [31:0] A_EX,
    input  logic [31:0] B_EX,
    input  logic        Abort_EX,
    output logic        Stall_EX,
    output logic [31:0] Result_EX,
    output logic        Busy
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opr_q, opr_d;
    logic [31:0] dividend_q, dividend_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;

    logic        need;
    logic        signed_op;
    logic        sign_a, sign_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_acc;
    logic [32:0] rem_shift, rem_diff;
    logic [63:0] div_acc;
    logic [63:0] prod_fixed;
    logic [31:0] quo_fixed, rem_fixed;

    assign need      = (MDop_EX >= OP_MULT) && (MDop_EX <= OP_MFLO);
    assign signed_op = (MDop_EX == OP_MULT) || (MDop_EX == OP_DIV);
    assign sign_a    = signed_op & A_EX[31];
    assign sign_b    = signed_op & B_EX[31];
    assign abs_a     = sign_a ? (~A_EX + 32'd1) : A_EX;
    assign abs_b     = sign_b ? (~B_EX + 32'd1) : B_EX;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opr_q} : 33'd0);
    assign mul_acc = {mul_sum, acc_q[31:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left with a trial subtract.
    assign rem_shift = {acc_q[63:32], acc_q[31]};
    assign rem_diff  = rem_shift - {1'b0, opr_q};
    assign div_acc   = rem_diff[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                                    : {rem_diff[31:0],  acc_q[30:0], 1'b1};

    assign prod_fixed = neg_q     ? (~acc_q + 64'd1)         : acc_q;
    assign quo_fixed  = neg_q     ? (~acc_q[31:0] + 32'd1)   : acc_q[31:0];
    assign rem_fixed  = neg_rem_q ? (~acc_q[63:32] + 32'd1)  : acc_q[63:32];

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opr_d      = opr_q;
        dividend_d = dividend_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;

        Busy      = (state_q != S_IDLE);
        Stall_EX  = need && (state_q != S_IDLE);
        Result_EX = 32'd0;
        if (state_q == S_IDLE) begin
            if (MDop_EX == OP_MFHI) Result_EX = hi_q;
            if (MDop_EX == OP_MFLO) Result_EX = lo_q;
        end

        case (state_q)
            S_IDLE: begin
                if (need && !Abort_EX) begin
                    case (MDop_EX)
                        OP_MTHI: hi_d = A_EX;
                        OP_MTLO: lo_d = A_EX;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d   = (MDop_EX == OP_DIV) || (MDop_EX == OP_DIVU);
                            acc_d      = is_div_d ? {32'd0, abs_a} : {32'd0, abs_b};
                            opr_d      = is_div_d ? abs_b : abs_a;
                            neg_d      = sign_a ^ sign_b;
                            neg_rem_d  = sign_a;
                            div0_d     = (B_EX == 32'd0);
                            dividend_d = A_EX;
                            count_d    = 6'd0;
                            state_d    = S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (Abort_EX) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_acc : mul_acc;
                    if (count_q == 6'd31) state_d = S_FIX;
                    else                  count_d = count_q + 6'd1;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!Abort_EX) begin
                    if (!is_div_q) begin
                        hi_d = prod_fixed[63:32];
                        lo_d = prod_fixed[31:0];
                    end else if (div0_q) begin
                        hi_d = dividend_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_fixed;
                        lo_d = quo_fixed;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            count_q    <= 6'd0;
            acc_q      <= 64'd0;
            opr_q      <= 32'd0;
            dividend_q <= 32'd0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            opr_q      <= opr_d;
            dividend_q <= dividend_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  MDop_EX;
    logic [31:0] A_EX, B_EX;
    logic        Abort_EX;
    logic        Stall_EX;
    logic [31:0] Result_EX;
    logic        Busy;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb_q[$];

    localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

    muldiv_sequencer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MDop_EX   (MDop_EX),
        .A_EX      (A_EX),
        .B_EX      (B_EX),
        .Abort_EX  (Abort_EX),
        .Stall_EX  (Stall_EX),
        .Result_EX (Result_EX),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted MFHI/MFLO is a DUT response to score.
    always @(negedge CLK) begin
        if (!RESET && !Abort_EX && !Stall_EX && (MDop_EX == MFHI || MDop_EX == MFLO)) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read: got 0x%08h, expected no response", Result_EX);
            end else begin
                logic [31:0] exp;
                exp = sb_q.pop_front();
                if (Result_EX !== exp) begin
                    miscompares++;
                    $display("FAIL read_result: got 0x%08h, expected 0x%08h", Result_EX, exp);
                end
            end
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        MDop_EX = op;
        A_EX    = a;
        B_EX    = b;
        stalls  = 0;
        @(negedge CLK);
        while (Stall_EX && stalls < 100) begin
            stalls++;
            @(negedge CLK);
        end
        if (stalls >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got %0d stall cycles, expected fewer than 100", stalls);
        end
        @(posedge CLK);
        #1;
        MDop_EX = 4'd0;
        A_EX    = 32'd0;
        B_EX    = 32'd0;
    endtask

    task automatic rd(input logic [3:0] op, input logic [31:0] exp, output int stalls);
        sb_q.push_back(exp);
        do_op(op, 32'd0, 32'd0, stalls);
    endtask

    initial begin
        int st;
        RESET = 1'b1; MDop_EX = 4'd0; A_EX = 32'd0; B_EX = 32'd0; Abort_EX = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_stall", {31'd0, Stall_EX}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_result", Result_EX, 32'd0);
        RESET = 1'b0;

        rd(MFHI, 32'd0, st); check("mfhi_reset_stall", st, 32'd0);
        rd(MFLO, 32'd0, st); check("mflo_reset_stall", st, 32'd0);

        do_op(MULT, 32'hFFFF_FFFD, 32'd7, st);
        rd(MFLO, 32'hFFFF_FFEB, st); check("mult_stall_cycles", st, 32'd33);
        rd(MFHI, 32'hFFFF_FFFF, st); check("mfhi_after_mult_stall", st, 32'd0);

        do_op(MULTU, 32'hFFFF_FFFD, 32'd7, st);
        rd(MFHI, 32'h0000_0006, st); check("multu_stall_cycles", st, 32'd33);
        rd(MFLO, 32'hFFFF_FFEB, st);

        do_op(DIV, 32'hFFFF_FFF9, 32'd2, st);
        rd(MFLO, 32'hFFFF_FFFD, st); check("div_stall_cycles", st, 32'd33);
        rd(MFHI, 32'hFFFF_FFFF, st);

        do_op(DIVU, 32'hFFFF_FFFF, 32'h10, st);
        rd(MFLO, 32'h0FFF_FFFF, st);
        rd(MFHI, 32'h0000_000F, st);

        do_op(DIVU, 32'd5, 32'd0, st);
        rd(MFLO, 32'hFFFF_FFFF, st);
        rd(MFHI, 32'd5, st);

        do_op(DIV, 32'hFFFF_FFFB, 32'd0, st);
        rd(MFLO, 32'hFFFF_FFFF, st);
        rd(MFHI, 32'hFFFF_FFFB, st);

        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
        rd(MFLO, 32'h8000_0000, st);
        rd(MFHI, 32'd0, st);

        // Abort ten cycles into a divide: HI/LO keep their old values.
        do_op(MTLO, 32'h1234_5678, 32'd0, st);
        do_op(DIV, 32'd9, 32'd3, st);
        repeat (9) @(posedge CLK);
        #1;
        check("busy_before_abort", {31'd0, Busy}, 32'd1);
        Abort_EX = 1'b1;
        @(posedge CLK);
        #1;
        Abort_EX = 1'b0;
        check("busy_after_abort", {31'd0, Busy}, 32'd0);
        rd(MFLO, 32'h1234_5678, st); check("mflo_after_abort_stall", st, 32'd0);
        rd(MFHI, 32'd0, st);

        // Reset in flight clears everything.
        do_op(MTLO, 32'h1234_5678, 32'd0, st);
        do_op(DIV, 32'd9, 32'd3, st);
        repeat (9) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("busy_after_reset", {31'd0, Busy}, 32'd0);
        rd(MFLO, 32'd0, st); check("mflo_after_reset_stall", st, 32'd0);

        // Independent instructions overlap; MTHI waits out the remaining cycles.
        do_op(MULT, 32'hFFFF_FFFF, 32'd5, st);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("nop_no_stall", {31'd0, Stall_EX}, 32'd0);
            check("nop_busy", {31'd0, Busy}, 32'd1);
            @(posedge CLK);
            #1;
        end
        do_op(MTHI, 32'h0000_00AA, 32'd0, st);
        check("mthi_stall_cycles", st, 32'd28);
        rd(MFHI, 32'h0000_00AA, st); check("mfhi_after_mthi_stall", st, 32'd0);
        rd(MFLO, 32'hFFFF_FFFB, st);

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit and HI/LO register owner for the pipelined MIPS core. Sits beside the ALU in EX, takes the MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operation decoded in RD, and runs multi-cycle operations on a shared shift/add-subtract datapath. Holds the pipeline with a stall whenever an EX instruction needs the unit or HI/LO while an operation is still in flight.

## Interface
- No parameters; data width fixed at 32.
- CLK  in  1  core clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- MDop_EX  in  4  op code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as none.
- A_EX  in  32  rs operand (multiplicand/dividend, MTHI/MTLO data).
- B_EX  in  32  rt operand (multiplier/divisor).
- Abort_EX  in  1  exception flush; cancels the in-flight operation.
- Stall_EX  out  1  hold EX and earlier stages this cycle.
- Result_EX  out  32  HI (MFHI) or LO (MFLO); 0 for other ops.
- Busy  out  1  operation in flight (state != IDLE).

## Operation
- States: IDLE, RUN, FIX. Registers: HI, LO, 6-bit iteration count, working accumulator/remainder, operand copies, sign flags.
- Need = MDop_EX in 1..8. Stall_EX = Need && state != IDLE (combinational). In IDLE, Stall_EX = 0.
- An op is accepted in a cycle where state == IDLE, MDop_EX in 1..8 and Abort_EX == 0.
- MTHI/MTLO accepted: HI/LO <= A_EX at that edge; state stays IDLE.
- MFHI/MFLO accepted: Result_EX = HI/LO combinationally in the same cycle. A write committed at an edge is visible to a read in the following cycle.
- MULT/MULTU/DIV/DIVU accepted: latch operands. Signed ops latch absolute values and record the sign of the result and of the remainder. Count <= 0, state <= RUN.
- RUN performs one radix-2 iteration per edge. MULT is shift-add over a 64-bit product. DIV is restoring shift-subtract. At count == 31 the state goes to FIX; otherwise count increments.
- FIX applies two's-complement sign correction and writes HI/LO, then state <= IDLE.
  - Multiply: {HI,LO} = 64-bit product; signed versus unsigned per op.
  - Divide: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend (raw A_EX), for both DIV and DIVU.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Abort_EX = 1 in RUN or FIX: state <= IDLE, HI/LO unchanged. Abort_EX in IDLE suppresses acceptance.
- RESET: state IDLE, HI = LO = 0, count = 0. It overrides everything, including an operation in flight.

## Timing
- Reset values: Stall_EX = 0, Busy = 0, Result_EX = 0.
- Accept a multiply/divide at edge E0. RUN occupies edges E1..E32 and FIX is edge E33. Busy is high from after E0 until E33, i.e. 33 cycles.
- HI/LO are valid from the cycle after E33.
- Back-to-back operation: a dependent MFHI/MFLO, or a second MULT/DIV, presented the cycle after E0 stalls for exactly 33 cycles. It is accepted in the cycle following E33 and sees the new HI/LO.
- An unrelated instruction (MDop_EX = 0) never stalls, so independent instructions overlap with the operation.
- Abort_EX and RESET take effect at the same edge they are sampled. No partial HI/LO write ever occurs.
- MTHI/MTLO during Busy stall; they cannot corrupt an in-flight result.

## Test plan
- RESET, then MFHI and MFLO in consecutive cycles -> Result_EX = 0 both, Stall_EX = 0.
- MULT A = 0xFFFFFFFD (-3), B = 7, then MFLO the next cycle -> Stall_EX high for 33 cycles; then Result_EX = 0xFFFFFFEB, and MFHI gives 0xFFFFFFFF. MULTU with the same operands -> HI = 0x00000006, LO = 0xFFFFFFEB.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 0x10 -> LO = 0x0FFFFFFF, HI = 0xF.
- DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 5.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- MTLO 0x12345678, then DIV 9/3, with Abort_EX pulsed 10 cycles after accept -> Busy drops at the next edge. A following MFLO returns 0x12345678 with no stall.
  - Repeat with RESET instead of the abort -> Busy = 0 and MFLO returns 0.
- MULT accepted, followed by 5 cycles of MDop_EX = 0 and then MTHI 0xAA -> no stall during the op = 0 cycles. MTHI stalls for the remaining 28 cycles and is accepted the cycle after FIX. MFHI then gives 0xAA, and LO keeps the product.
